// File: rtl/invader_march_if.sv
//============================================================================
// Module      : invader_march_if
// Description : Bundle of frame/wave controls, alive mask and grid outputs
//               exchanged between the invader state logic and invader_march.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface invader_march_if;
    logic        frame;
    logic        wave_start;
    logic [54:0] invaders;
    logic [9:0]  invaders_x;
    logic [9:0]  invaders_y;
    logic        step;
    logic        anim;
    logic        dir_left;
    logic        landed;
    logic        cleared;

    // Side that issues frames/waves and consumes the grid position
    modport master (
        output frame, wave_start, invaders,
        input  invaders_x, invaders_y, step, anim, dir_left, landed, cleared
    );

    // The march scheduler itself
    modport slave (
        input  frame, wave_start, invaders,
        output invaders_x, invaders_y, step, anim, dir_left, landed, cleared
    );
endinterface

`default_nettype wire

// File: rtl/invader_march.sv
//============================================================================
// Module      : invader_march
// Description : Movement scheduler for the 5x11 invader grid. Each frame it
//               scans the alive mask serially (55 cycles), then decides in
//               one cycle whether the grid steps sideways, drops or lands.
//               Optional macro MARCH_SPEEDUP_EN makes the step period shrink
//               with the number of survivors.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module invader_march #(
    parameter int START_X     = 64,
    parameter int START_Y     = 48,
    parameter int COL_PITCH   = 16,
    parameter int ROW_PITCH   = 16,
    parameter int INV_W       = 12,
    parameter int INV_H       = 8,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 8,
    parameter int LEFT_BOUND  = 8,
    parameter int RIGHT_BOUND = 600,
    parameter int FLOOR_Y     = 416,
    parameter int STEP_PERIOD = 8
) (
    input  logic          clk,
    input  logic          rst,
    invader_march_if.slave bus
);

    localparam logic [9:0]  c_START_X     = 10'(START_X);
    localparam logic [9:0]  c_START_Y     = 10'(START_Y);
    localparam logic [9:0]  c_STEP_X10    = 10'(STEP_X);
    localparam logic [9:0]  c_STEP_Y10    = 10'(STEP_Y);
    localparam logic [10:0] c_COL_PITCH   = 11'(COL_PITCH);
    localparam logic [10:0] c_ROW_PITCH   = 11'(ROW_PITCH);
    localparam logic [10:0] c_INV_W       = 11'(INV_W);
    localparam logic [10:0] c_INV_H       = 11'(INV_H);
    localparam logic [10:0] c_STEP_X11    = 11'(STEP_X);
    localparam logic [10:0] c_LEFT_BOUND  = 11'(LEFT_BOUND);
    localparam logic [10:0] c_RIGHT_BOUND = 11'(RIGHT_BOUND);
    localparam logic [10:0] c_FLOOR_Y     = 11'(FLOOR_Y);
    localparam logic [5:0]  c_LAST_IDX    = 6'd54;
`ifdef MARCH_SPEEDUP_EN
    // Full grid period: 1 + (55 >> 2); a fresh wave always starts full.
    localparam logic [5:0]  c_PERIOD_INIT = 6'd14;
`else
    localparam logic [5:0]  c_PERIOD_INIT = 6'(STEP_PERIOD);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DECIDE = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [5:0]  r_idx;
    logic [3:0]  r_col;
    logic [2:0]  r_row;
    logic [5:0]  r_alive_cnt;
    logic [10:0] r_col_occ;
    logic [4:0]  r_row_occ;
    logic [5:0]  r_frame_cnt;
    logic [9:0]  r_x, r_y;
    logic        r_step, r_anim, r_dir_left, r_landed, r_cleared;

    logic [3:0]  w_lmin, w_rmax;
    logic [2:0]  w_bmax;
    logic [10:0] w_left_edge, w_right_edge, w_bottom;
    logic [5:0]  w_period, w_cnt_eff, w_cnt_dec;
    logic        w_drop_right, w_drop_left;

`ifdef MARCH_SPEEDUP_EN
    assign w_period = 6'd1 + {2'b00, r_alive_cnt[5:2]};
`else
    assign w_period = c_PERIOD_INIT;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: frames only accepted in IDLE, wave_start aborts anything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.frame) w_state_next = S_SCAN;
            S_SCAN:   if (r_idx == c_LAST_IDX) w_state_next = S_DECIDE;
            S_DECIDE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (bus.wave_start) w_state_next = S_IDLE;
    end

    // Grid extents, edges, counter clamp and drop conditions for DECIDE
    always_comb begin
        w_lmin = 4'd0;
        w_rmax = 4'd0;
        w_bmax = 3'd0;
        for (int i = 10; i >= 0; i--) if (r_col_occ[i]) w_lmin = 4'(i);
        for (int i = 0; i <= 10; i++) if (r_col_occ[i]) w_rmax = 4'(i);
        for (int i = 0; i <= 4; i++)  if (r_row_occ[i]) w_bmax = 3'(i);
        w_left_edge  = {1'b0, r_x} + 11'(w_lmin) * c_COL_PITCH;
        w_right_edge = {1'b0, r_x} + 11'(w_rmax) * c_COL_PITCH + c_INV_W;
        w_bottom     = {1'b0, r_y} + 11'(w_bmax) * c_ROW_PITCH + c_INV_H;
        w_cnt_eff    = (r_frame_cnt > w_period) ? w_period : r_frame_cnt;
        w_cnt_dec    = w_cnt_eff - 6'd1;
        w_drop_right = !r_dir_left && ((w_right_edge + c_STEP_X11) > c_RIGHT_BOUND);
        w_drop_left  = r_dir_left && (w_left_edge < (c_LEFT_BOUND + c_STEP_X11));
    end

    // Scan accumulation, movement decision and grid position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= 6'd0;
            r_col       <= 4'd0;
            r_row       <= 3'd0;
            r_alive_cnt <= 6'd0;
            r_col_occ   <= 11'd0;
            r_row_occ   <= 5'd0;
            r_frame_cnt <= c_PERIOD_INIT;
            r_x         <= c_START_X;
            r_y         <= c_START_Y;
            r_step      <= 1'b0;
            r_anim      <= 1'b0;
            r_dir_left  <= 1'b0;
            r_landed    <= 1'b0;
            r_cleared   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (bus.wave_start) begin
                r_x         <= c_START_X;
                r_y         <= c_START_Y;
                r_dir_left  <= 1'b0;
                r_landed    <= 1'b0;
                r_cleared   <= 1'b0;
                r_frame_cnt <= c_PERIOD_INIT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.frame) begin
                            r_idx       <= 6'd0;
                            r_col       <= 4'd0;
                            r_row       <= 3'd0;
                            r_alive_cnt <= 6'd0;
                            r_col_occ   <= 11'd0;
                            r_row_occ   <= 5'd0;
                        end
                    end
                    S_SCAN: begin
                        if (bus.invaders[r_idx]) begin
                            r_alive_cnt       <= r_alive_cnt + 6'd1;
                            r_col_occ[r_col]  <= 1'b1;
                            r_row_occ[r_row]  <= 1'b1;
                        end
                        r_idx <= r_idx + 6'd1;
                        if (r_col == 4'd10) begin
                            r_col <= 4'd0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 4'd1;
                        end
                    end
                    S_DECIDE: begin
                        r_cleared <= (r_alive_cnt == 6'd0);
                        if (r_alive_cnt != 6'd0) begin
                            if (r_landed || (w_bottom >= c_FLOOR_Y)) begin
                                r_landed <= 1'b1;
                            end else if (w_cnt_dec != 6'd0) begin
                                r_frame_cnt <= w_cnt_dec;
                            end else begin
                                r_frame_cnt <= w_period;
                                r_step      <= 1'b1;
                                r_anim      <= ~r_anim;
                                if (w_drop_right) begin
                                    r_y        <= r_y + c_STEP_Y10;
                                    r_dir_left <= 1'b1;
                                end else if (w_drop_left) begin
                                    r_y        <= r_y + c_STEP_Y10;
                                    r_dir_left <= 1'b0;
                                end else if (r_dir_left) begin
                                    r_x <= r_x - c_STEP_X10;
                                end else begin
                                    r_x <= r_x + c_STEP_X10;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.invaders_x = r_x;
    assign bus.invaders_y = r_y;
    assign bus.step       = r_step;
    assign bus.anim       = r_anim;
    assign bus.dir_left   = r_dir_left;
    assign bus.landed     = r_landed;
    assign bus.cleared    = r_cleared;

endmodule

`default_nettype wire

// File: tb/tb_invader_march.sv
//============================================================================
// Module      : tb_invader_march
// Description : Directed bench for invader_march. Main instance starts at
//               (424,320) so edge drops are reached quickly; a second
//               instance starts at (424,336) so one drop reaches the floor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_invader_march;

`ifdef MARCH_SPEEDUP_EN
    localparam int P_FULL = 14;   // 1 + (55 >> 2)
    localparam int P_ONE  = 1;    // 1 + (1 >> 2)
`else
    localparam int P_FULL = 8;
    localparam int P_ONE  = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    invader_march_if bus_a ();
    invader_march_if bus_b ();

    invader_march #(.START_X(424), .START_Y(320)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    invader_march #(.START_X(424), .START_Y(336)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [54:0] mask;
        int          steps;
        int          max_frames;
        int          x, y, dir, anim, cleared;
    } vec_t;

    vec_t        tbl [8];
    int          n_pass = 0;
    int          n_total = 0;
    logic [54:0] m_full, m_col0, m_bot, m_one;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // One frame pulse on both instances; counts step cycles over the next 60 cycles.
    // ws adds a coincident wave_start on instance A; extra>0 re-pulses frame mid-scan.
    task automatic run_frame(input bit ws, input int extra, output int s1, output int s2);
        s1 = 0; s2 = 0;
        @(negedge clk);
        bus_a.frame = 1'b1; bus_b.frame = 1'b1;
        if (ws) bus_a.wave_start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus_a.frame = 1'b0; bus_b.frame = 1'b0; bus_a.wave_start = 1'b0;
            end
            if (extra > 0 && k == extra)     begin bus_a.frame = 1'b1; bus_b.frame = 1'b1; end
            if (extra > 0 && k == extra + 1) begin bus_a.frame = 1'b0; bus_b.frame = 1'b0; end
            if (bus_a.step) s1++;
            if (bus_b.step) s2++;
        end
    endtask

    task automatic pulse_wave(input bit on_a, input bit on_b);
        @(negedge clk);
        bus_a.wave_start = on_a; bus_b.wave_start = on_b;
        @(negedge clk);
        bus_a.wave_start = 1'b0; bus_b.wave_start = 1'b0;
    endtask

    initial begin
        int s1, s2, tot;
        m_full = '1;
        m_col0 = '0;
        for (int r = 0; r < 5; r++) m_col0[r*11] = 1'b1;
        m_bot = '0;
        for (int c = 0; c < 11; c++) m_bot[44+c] = 1'b1;
        m_one = '0;
        m_one[0] = 1'b1;

        //          mask    steps max        x    y  dir anim clr
        tbl[0] = '{m_full,  1,  20,        428, 320, 0, 0, 0};
        tbl[1] = '{m_full,  1,  20,        428, 328, 1, 1, 0};
        tbl[2] = '{m_full,  1,  20,        426, 328, 1, 0, 0};
        tbl[3] = '{m_col0,  82, 82*15+2,   588, 320, 0, 0, 0};
        tbl[4] = '{m_col0,  1,  20,        588, 328, 1, 1, 0};
        tbl[5] = '{m_col0,  1,  20,        586, 328, 1, 0, 0};
        tbl[6] = '{'0,      0,  3,         586, 328, 1, 0, 1};
        tbl[7] = '{m_col0,  1,  20,        584, 328, 1, 1, 0};

        bus_a.frame = 0; bus_a.wave_start = 0; bus_a.invaders = m_full;
        bus_b.frame = 0; bus_b.wave_start = 0; bus_b.invaders = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_x", bus_a.invaders_x, 424);
        check("rst_y", bus_a.invaders_y, 320);
        check("rst_step", bus_a.step, 0);
        check("rst_anim", bus_a.anim, 0);
        check("rst_dir", bus_a.dir_left, 0);
        check("rst_landed", bus_a.landed, 0);
        check("rst_cleared", bus_a.cleared, 0);
        check("rst_b_y", bus_b.invaders_y, 336);

        // Full grid: first P_FULL-1 frames are silent (last one has a mid-scan frame)
        tot = 0;
        for (int f = 1; f < P_FULL; f++) begin
            run_frame(1'b0, (f == P_FULL - 1) ? 20 : 0, s1, s2);
            tot += s1;
        end
        check("no_early_step", tot, 0);
        check("no_early_move", bus_a.invaders_x, 424);

        // Frame P_FULL: step lands exactly 57 cycles after the frame pulse
        @(negedge clk);
        bus_a.frame = 1'b1; bus_b.frame = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin bus_a.frame = 1'b0; bus_b.frame = 1'b0; end
            if (k >= 56 && k <= 58) check($sformatf("step_at_%0d", k), bus_a.step, (k == 57) ? 1 : 0);
        end
        check("first_x", bus_a.invaders_x, 426);
        check("first_y", bus_a.invaders_y, 320);
        check("first_anim", bus_a.anim, 1);

        // Table phases (restart before the column-0 phase)
        for (int r = 0; r < 8; r++) begin
            if (r == 3) begin
                pulse_wave(1'b1, 1'b0);
                check("ws_x", bus_a.invaders_x, 424);
                check("ws_y", bus_a.invaders_y, 320);
                check("ws_dir", bus_a.dir_left, 0);
            end
            bus_a.invaders = tbl[r].mask;
            tot = 0;
            for (int f = 0; f < tbl[r].max_frames; f++) begin
                if (tbl[r].steps > 0 && tot >= tbl[r].steps) break;
                run_frame(1'b0, 0, s1, s2);
                tot += s1;
            end
            check($sformatf("v%0d_steps", r), tot, tbl[r].steps);
            check($sformatf("v%0d_x", r), bus_a.invaders_x, tbl[r].x);
            check($sformatf("v%0d_y", r), bus_a.invaders_y, tbl[r].y);
            check($sformatf("v%0d_dir", r), bus_a.dir_left, tbl[r].dir);
            check($sformatf("v%0d_anim", r), bus_a.anim, tbl[r].anim);
            check($sformatf("v%0d_cleared", r), bus_a.cleared, tbl[r].cleared);
        end

        // Single invader: step every P_ONE frames
        pulse_wave(1'b1, 1'b0);
        bus_a.invaders = m_one;
        for (int f = 1; f <= 2 * P_ONE; f++) begin
            run_frame(1'b0, 0, s1, s2);
            check($sformatf("one_f%0d", f), s1, (f % P_ONE == 0) ? 1 : 0);
        end
        check("one_x", bus_a.invaders_x, 428);

        // wave_start coincident with frame: restart wins, no scan that cycle
        run_frame(1'b1, 0, s1, s2);
        check("coinc_step", s1, 0);
        check("coinc_x", bus_a.invaders_x, 424);
        for (int f = 1; f <= P_ONE; f++) begin
            run_frame(1'b0, 0, s1, s2);
            check($sformatf("coinc_f%0d", f), s1, (f == P_ONE) ? 1 : 0);
        end

        // Landing on instance B: bottom row only, one drop reaches the floor
        bus_a.invaders = '0;
        bus_b.invaders = m_bot;
        pulse_wave(1'b0, 1'b1);
        tot = 0;
        for (int f = 0; f < 3 * 15 + 2; f++) begin
            if (tot >= 3) break;
            run_frame(1'b0, 0, s1, s2);
            tot += s2;
        end
        check("land_steps", tot, 3);
        check("land_drop_y", bus_b.invaders_y, 344);
        check("land_pre", bus_b.landed, 0);
        run_frame(1'b0, 0, s1, s2);
        check("land_set", bus_b.landed, 1);
        tot = s2;
        for (int f = 0; f < P_FULL + 1; f++) begin
            run_frame(1'b0, 0, s1, s2);
            tot += s2;
        end
        check("land_frozen_steps", tot, 0);
        check("land_frozen_x", bus_b.invaders_x, 428);
        check("land_frozen_y", bus_b.invaders_y, 344);
        pulse_wave(1'b0, 1'b1);
        check("land_ws_x", bus_b.invaders_x, 424);
        check("land_ws_y", bus_b.invaders_y, 336);
        check("land_ws_landed", bus_b.landed, 0);

        // Asynchronous reset in the middle of a scan
        pulse_wave(1'b1, 1'b0);
        bus_a.invaders = m_one;
        run_frame(1'b0, 0, s1, s2);    // moves A off its start position
        check("pre_rst_x", bus_a.invaders_x, (P_ONE == 1) ? 426 : 424);
        @(negedge clk);
        bus_a.frame = 1'b1;
        @(negedge clk);
        bus_a.frame = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_x", bus_a.invaders_x, 424);
        check("rst_mid_dir", bus_a.dir_left, 0);
        @(negedge clk);
        rst = 1'b0;
        tot = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus_a.step) tot++;
        end
        check("rst_mid_no_step", tot, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
